// File: rtl/cluster_pkg.sv
// Shared types and helpers for the PE-cluster output path.
// Holds the drain FSM state type, the default accumulator width and a sign-extension helper.
// Pure declarations: no logic, so no latency or backpressure of its own.
package cluster_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } psum_state_t;

    localparam int PSUM_ACC_WIDTH = 24;

    // Sign-extend the low w bits of v to 64 bits. Callers truncate the result to
    // their own width, so any accumulator up to 64 bits wide is covered.
    function automatic logic [63:0] sext(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 64; b++) begin
            r[6'(b)] = (b < w) ? v[6'(b)] : v[6'(w - 1)];
        end
        return r;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector on a level signal.
// Latency: rise_o is combinational on sig_i against the registered previous value.
// No backpressure. The delayed bit resets to 1, so a level that is already high
// when reset releases does not count as an edge.
//
// Ports: clk, reset (sync, active-high), sig_i (level), rise_o (sig_i & ~previous sig_i).
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dly_q <= 1'b1;
        end else begin
            dly_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~dly_q;

endmodule

// File: rtl/psum_accum_drain.sv
// Accumulates X_dim cluster row sums over NUM_PASSES compute_done edges, then drains them serially.
// Latency: the final pass capture at edge t presents row 0 on out_valid in cycle t+1; one row per handshake.
// Backpressure: out_ready stalls the drain with outputs held; passes arriving mid-drain are dropped and flagged.
//
// Ports: clk, reset (sync, active-high); pe_out[X_dim] row psums sampled on compute_done rise;
//        out_data/out_row/out_last/out_valid/out_ready serial result port;
//        accum_ready (able to take a pass); drop_err (sticky, pass discarded while draining).
module psum_accum_drain
    import cluster_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int X_dim      = 3,
    parameter  int ACC_WIDTH  = PSUM_ACC_WIDTH,
    parameter  int NUM_PASSES = 4,
    localparam int RW         = (X_dim > 1) ? $clog2(X_dim) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pe_out [0:X_dim-1],
    input  logic                  compute_done,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic [RW-1:0]         out_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  accum_ready,
    output logic                  drop_err
);

    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [PW-1:0] LAST_PASS = PW'(NUM_PASSES - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(X_dim - 1);

    psum_state_t          state_q, state_d;
    logic [PW-1:0]        pass_cnt_q, pass_cnt_d;
    logic [RW-1:0]        row_q, row_d;
    logic                 drop_err_q, drop_err_d;
    logic                 cap;
    logic                 acc_add;
    logic                 acc_clr;
    logic [ACC_WIDTH-1:0] acc_row [0:X_dim-1];

    rise_detect u_done_rise (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (compute_done),
        .rise_o (cap)
    );

    // Pass counting and drain sequencing. A capture while draining never
    // touches the sums; it only raises the sticky drop flag. That includes a
    // capture coinciding with the last-row handshake.
    always_comb begin
        state_d    = state_q;
        pass_cnt_d = pass_cnt_q;
        row_d      = row_q;
        drop_err_d = drop_err_q;
        acc_add    = 1'b0;
        acc_clr    = 1'b0;
        case (state_q)
            ACCUM: begin
                if (cap) begin
                    acc_add = 1'b1;
                    if (pass_cnt_q == LAST_PASS) begin
                        pass_cnt_d = '0;
                        row_d      = '0;
                        state_d    = DRAIN;
                    end else begin
                        pass_cnt_d = pass_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (cap) begin
                    drop_err_d = 1'b1;
                end
                if (out_ready) begin
                    if (row_q == LAST_ROW) begin
                        acc_clr = 1'b1;
                        row_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACCUM;
            pass_cnt_q <= '0;
            row_q      <= '0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_cnt_q <= pass_cnt_d;
            row_q      <= row_d;
            drop_err_q <= drop_err_d;
        end
    end

    // One accumulator per cluster row; sums wrap modulo 2^ACC_WIDTH.
    for (genvar i = 0; i < X_dim; i++) begin : g_row
        logic [ACC_WIDTH-1:0] acc_q, acc_d;

        always_comb begin
            acc_d = acc_q;
            if (acc_clr) begin
                acc_d = '0;
            end else if (acc_add) begin
                acc_d = acc_q + ACC_WIDTH'(sext(64'(pe_out[i]), DATA_WIDTH));
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end

        assign acc_row[i] = acc_q;
    end

    // All outputs derive from registered state only.
    assign out_valid   = (state_q == DRAIN);
    assign accum_ready = (state_q == ACCUM);
    assign out_row     = row_q;
    assign out_last    = (state_q == DRAIN) && (row_q == LAST_ROW);
    assign out_data    = (state_q == DRAIN) ? acc_row[row_q] : '0;
    assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_psum_accum_drain.sv
module tb_psum_accum_drain;

    logic        clk;
    logic        reset;
    logic [15:0] pe_out [0:2];
    logic        compute_done;
    logic [23:0] out_data;
    logic [1:0]  out_row;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        accum_ready;
    logic        drop_err;

    psum_accum_drain #(
        .DATA_WIDTH (16),
        .X_dim      (3),
        .ACC_WIDTH  (24),
        .NUM_PASSES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pe_out       (pe_out),
        .compute_done (compute_done),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .accum_ready  (accum_ready),
        .drop_err     (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  row;
        logic [23:0] data;
        logic        last;
    } beat_t;

    beat_t       sbq[$];
    logic [23:0] m_acc [0:2];
    int          m_pass;
    bit          m_drain;
    bit          m_drop;
    bit          m_prev;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the DUT against the model for the current cycle, then advance the
    // model by what the coming clock edge should do and take that edge.
    task automatic step();
        bit    cap;
        beat_t b;
        chk("out_valid", 32'(out_valid), 32'(m_drain));
        chk("accum_ready", 32'(accum_ready), 32'(!m_drain));
        chk("drop_err", 32'(drop_err), 32'(m_drop));
        if (m_drain && sbq.size() > 0) begin
            chk("out_row", 32'(out_row), 32'(sbq[0].row));
            chk("out_data", 32'(out_data), 32'(sbq[0].data));
            chk("out_last", 32'(out_last), 32'(sbq[0].last));
        end
        cap    = compute_done && !m_prev;
        m_prev = compute_done;
        if (m_drain) begin
            if (cap) m_drop = 1'b1;
            if (out_ready && sbq.size() > 0) begin
                void'(sbq.pop_front());
                if (sbq.size() == 0) begin
                    m_drain = 1'b0;
                    for (int r = 0; r < 3; r++) m_acc[r] = '0;
                end
            end
        end else if (cap) begin
            for (int r = 0; r < 3; r++) m_acc[r] = m_acc[r] + {{8{pe_out[r][15]}}, pe_out[r]};
            m_pass++;
            if (m_pass == 4) begin
                m_pass = 0;
                for (int r = 0; r < 3; r++) begin
                    b.row  = 2'(r);
                    b.data = m_acc[r];
                    b.last = (r == 2);
                    sbq.push_back(b);
                end
                m_drain = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int r = 0; r < 3; r++) m_acc[r] = '0;
        m_pass  = 0;
        m_drain = 1'b0;
        m_drop  = 1'b0;
        m_prev  = 1'b1;
        sbq.delete();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_row", 32'(out_row), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_accum_ready", 32'(accum_ready), 32'd1);
        chk("rst_drop_err", 32'(drop_err), 32'd0);
    endtask

    // One pass: values present only in the rising cycle, junk afterwards.
    task automatic pass(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        pe_out[0] = a;
        pe_out[1] = b;
        pe_out[2] = c;
        compute_done = 1'b1;
        step();
        compute_done = 1'b0;
        for (int r = 0; r < 3; r++) pe_out[r] = 16'($urandom);
        step();
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b1;
        compute_done = 1'b0;
        out_ready    = 1'b1;
        for (int r = 0; r < 3; r++) pe_out[r] = '0;
        do_reset();
        idle(2);

        // T1: plain accumulation, full-rate drain
        repeat (4) pass(16'd1, 16'd2, 16'd3);
        idle(5);

        // T2: negative input sign-extended
        repeat (4) pass(16'hFFFF, 16'h8000, 16'h7FFF);
        idle(5);

        // T3: stall the drain for 5 cycles on row 0
        repeat (3) pass(16'd5, 16'd6, 16'd7);
        out_ready = 1'b0;
        pass(16'd5, 16'd6, 16'd7);
        idle(5);
        out_ready = 1'b1;
        idle(5);

        // T4: pass during stalled drain is dropped, next tile excludes it
        out_ready = 1'b0;
        repeat (4) pass(16'd10, 16'd20, 16'd30);
        pass(16'd100, 16'd100, 16'd100);
        out_ready = 1'b1;
        idle(4);
        repeat (4) pass(16'd1, 16'd1, 16'd1);
        idle(4);

        // T4b: pass edge coinciding with the last-row handshake is dropped
        repeat (4) pass(16'd2, 16'd0, 16'd0);
        step();
        pe_out[0] = 16'd50;
        compute_done = 1'b1;
        step();
        compute_done = 1'b0;
        idle(3);
        repeat (4) pass(16'd3, 16'd3, 16'd3);
        idle(4);

        // T5: level held high counts once; high through reset release is no pass
        pe_out[0] = 16'd7; pe_out[1] = 16'd8; pe_out[2] = 16'd9;
        compute_done = 1'b1;
        idle(10);
        compute_done = 1'b0;
        step();
        repeat (3) pass(16'd1, 16'd1, 16'd1);
        idle(4);
        compute_done = 1'b1;
        do_reset();
        idle(3);
        compute_done = 1'b0;
        step();
        repeat (4) pass(16'd4, 16'd5, 16'd6);
        idle(4);

        // T6: reset mid-tile and mid-drain
        repeat (2) pass(16'd9, 16'd9, 16'd9);
        do_reset();
        repeat (4) pass(16'd1, 16'd2, 16'd4);
        idle(4);
        out_ready = 1'b0;
        repeat (4) pass(16'd3, 16'd3, 16'd3);
        idle(2);
        do_reset();
        out_ready = 1'b1;
        idle(2);
        repeat (4) pass(16'd2, 16'd2, 16'd2);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
